// File: rtl/pose_score_judge.sv
// rtl/pose_score_judge.sv - frame-level pose match judge with sequential divider
//
// Counts person pixels inside (hit) and outside (miss) the pose polygon over one
// full frame. It then computes score = floor(hit*100 / (hit+miss)) with a
// restoring divider and presents a registered perfect/good/bad verdict.
//
// Ports:
//   clk, rst_n     pixel clock, asynchronous active-low reset
//   judge_req      one-cycle request to judge the next full frame
//   frame_start    one-cycle pulse at the first active pixel of each frame
//   de             active-video pixel valid
//   in_polygon     pixel lies inside the pose polygon
//   chroma         pixel is chroma background (no person)
//   busy           high from accepted request until result_valid
//   result_valid   one-cycle pulse when a new verdict is presented
//   score          match percentage 0..100
//   perfect/good/bad  one-hot verdict, held until the next result

module pose_score_judge #(
  parameter int H_ACT      = 640,
  parameter int V_ACT      = 480,
  parameter int CNT_W      = 19,
  parameter int PERFECT_TH = 80,
  parameter int GOOD_TH    = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       judge_req,
  input  logic       frame_start,
  input  logic       de,
  input  logic       in_polygon,
  input  logic       chroma,
  output logic       busy,
  output logic       result_valid,
  output logic [6:0] score,
  output logic       perfect,
  output logic       good,
  output logic       bad
);

  localparam int NUM_W = CNT_W + 7;
  localparam int DEN_W = CNT_W + 1;
  localparam int REM_W = CNT_W + 2;
  localparam int DCW   = $clog2(NUM_W);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(NUM_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A full frame of person pixels must fit in the counters.
  if (CNT_W < $clog2(H_ACT * V_ACT)) begin : g_cnt_w_check
    $error("CNT_W too small for H_ACT*V_ACT");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_ACCUM = 3'd2,
    S_DIV   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] hit_cnt, miss_cnt;
  logic [NUM_W-1:0] num_q;     // dividend, shifted out MSB-first while quotient bits shift in
  logic [DEN_W-1:0] den_q;
  logic [REM_W-1:0] rem_q;
  logic [DCW-1:0]   div_cnt;

  logic             count_en;
  logic             pix_hit, pix_miss;
  logic [REM_W-1:0] rem_sh, rem_nxt;
  logic             q_bit;
  logic [6:0]       q_final;
  logic             div_zero;

  // The opening frame_start pixel (seen in ARMED) is counted; the closing one is not.
  assign count_en = (state == S_ARMED && frame_start) || (state == S_ACCUM && !frame_start);
  assign pix_hit  = de && !chroma && in_polygon;
  assign pix_miss = de && !chroma && !in_polygon;
  assign div_zero = (den_q == '0);

  // One restoring-division step.
  assign rem_sh  = {rem_q[REM_W-2:0], num_q[NUM_W-1]};
  assign q_bit   = (rem_sh >= {1'b0, den_q});
  assign rem_nxt = q_bit ? (rem_sh - {1'b0, den_q}) : rem_sh;
  // Quotient never exceeds 100, so only its low 7 bits matter.
  assign q_final = {num_q[5:0], q_bit};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (judge_req)   state_nxt = S_ARMED;
      S_ARMED: if (frame_start) state_nxt = S_ACCUM;
      S_ACCUM: if (frame_start) state_nxt = S_DIV;
      S_DIV:   if (div_zero || div_cnt == DIV_LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state)
      S_ARMED, S_ACCUM, S_DIV: busy = 1'b1;
      S_DONE:                  result_valid = 1'b1;
      default: ;
    endcase
  end

  // Saturating pixel counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (state == S_IDLE && judge_req) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (count_en) begin
      if (pix_hit && hit_cnt != CNT_MAX)   hit_cnt  <= hit_cnt + 1'b1;
      if (pix_miss && miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + 1'b1;
    end
  end

  // Divider datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q   <= '0;
      den_q   <= '0;
      rem_q   <= '0;
      div_cnt <= '0;
    end else if (state == S_ACCUM && frame_start) begin
      num_q   <= NUM_W'(hit_cnt) * NUM_W'(100);
      den_q   <= {1'b0, hit_cnt} + {1'b0, miss_cnt};
      rem_q   <= '0;
      div_cnt <= '0;
    end else if (state == S_DIV && !div_zero) begin
      num_q   <= {num_q[NUM_W-2:0], q_bit};
      rem_q   <= rem_nxt;
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Score and verdict are loaded as the FSM enters DONE, so they are
  // already stable while result_valid is high and hold afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score   <= '0;
      perfect <= 1'b0;
      good    <= 1'b0;
      bad     <= 1'b0;
    end else if (state == S_DIV && state_nxt == S_DONE) begin
      if (div_zero) begin
        score   <= '0;
        perfect <= 1'b0;
        good    <= 1'b0;
        bad     <= 1'b1;
      end else begin
        score   <= q_final;
        perfect <= (q_final >= 7'(PERFECT_TH));
        good    <= (q_final >= 7'(GOOD_TH)) && (q_final < 7'(PERFECT_TH));
        bad     <= (q_final < 7'(GOOD_TH));
      end
    end
  end

endmodule

// File: tb/tb_pose_score_judge.sv
// tb/tb_pose_score_judge.sv - self-checking bench for pose_score_judge

module tb_pose_score_judge;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       judge_req = 1'b0;
  logic       frame_start = 1'b0;
  logic       de = 1'b0;
  logic       in_polygon = 1'b0;
  logic       chroma = 1'b0;
  logic       busy;
  logic       result_valid;
  logic [6:0] score;
  logic       perfect;
  logic       good;
  logic       bad;

  int total = 0;
  int n_bad = 0;

  pose_score_judge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .judge_req    (judge_req),
    .frame_start  (frame_start),
    .de           (de),
    .in_polygon   (in_polygon),
    .chroma       (chroma),
    .busy         (busy),
    .result_valid (result_valid),
    .score        (score),
    .perfect      (perfect),
    .good         (good),
    .bad          (bad)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // 0 = hit, 1 = miss, 2 = chroma pixel, 3 = blanking pixel
  task automatic drive_pix(input int code);
    case (code)
      0: begin de = 1'b1; chroma = 1'b0; in_polygon = 1'b1; end
      1: begin de = 1'b1; chroma = 1'b0; in_polygon = 1'b0; end
      2: begin de = 1'b1; chroma = 1'b1; in_polygon = 1'($urandom); end
      default: begin de = 1'b0; chroma = 1'($urandom); in_polygon = 1'($urandom); end
    endcase
  endtask

  // Judge one frame containing nh hits, nm misses and nnoise uncounted pixels.
  task automatic judge(input string name, input int nh, input int nm, input int nnoise,
                       input bit open_hit, input bit close_hit,
                       input bit extra_req, input bit done_req);
    int q[$];
    int tmp, j, d, exp_score, exp_lat, lat, rv_n;
    int s_score, s_perf, s_good, s_bad, s_busy;
    for (int i = 0; i < nh; i++) q.push_back(0);
    for (int i = 0; i < nm; i++) q.push_back(1);
    for (int i = 0; i < nnoise; i++) q.push_back(2 + int'($urandom_range(1, 0)));
    for (int i = q.size() - 1; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = q[i]; q[i] = q[j]; q[j] = tmp;
    end
    if (open_hit) begin
      for (int i = 0; i < q.size(); i++)
        if (q[i] == 0) begin tmp = q[0]; q[0] = q[i]; q[i] = tmp; break; end
    end

    d = nh + nm;
    exp_score = (d == 0) ? 0 : (nh * 100) / d;
    exp_lat   = (d == 0) ? 2 : 27;

    @(negedge clk); judge_req = 1'b1; frame_start = 1'b0; de = 1'b0;
    @(negedge clk); judge_req = 1'b0;
    @(negedge clk);
    chk({name, ".busy_armed"}, int'(busy), 1);
    for (int i = 0; i < q.size(); i++) begin
      frame_start = (i == 0);
      drive_pix(q[i]);
      judge_req = extra_req && (i == q.size() / 2);
      @(negedge clk);
    end
    frame_start = 1'b1;
    judge_req   = 1'b0;
    drive_pix(close_hit ? 0 : 3);

    lat = -1; rv_n = 0;
    s_score = -1; s_perf = -1; s_good = -1; s_bad = -1; s_busy = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      frame_start = 1'b0;
      de = 1'b0;
      if (k == 1) chk({name, ".busy_div"}, int'(busy), (d == 0) ? 1 : 1);
      if (result_valid) begin
        rv_n++;
        if (lat < 0) begin
          lat = k;
          s_score = int'(score); s_perf = int'(perfect);
          s_good = int'(good); s_bad = int'(bad); s_busy = int'(busy);
        end
      end
      judge_req = done_req && (k == exp_lat);
    end
    judge_req = 1'b0;

    chk({name, ".latency"}, lat, exp_lat);
    chk({name, ".rv_count"}, rv_n, 1);
    chk({name, ".score"}, s_score, exp_score);
    chk({name, ".perfect"}, s_perf, int'(exp_score >= 80));
    chk({name, ".good"}, s_good, int'(exp_score >= 50 && exp_score < 80));
    chk({name, ".bad"}, s_bad, int'(exp_score < 50));
    chk({name, ".busy_done"}, s_busy, 0);
    chk({name, ".busy_after"}, int'(busy), 0);
    chk({name, ".score_hold"}, int'(score), exp_score);
  endtask

  initial begin
    int rv_n;
    int nh, nm;

    repeat (3) @(negedge clk);
    chk("rst.busy", int'(busy), 0);
    chk("rst.rv", int'(result_valid), 0);
    chk("rst.score", int'(score), 0);
    chk("rst.perfect", int'(perfect), 0);
    chk("rst.good", int'(good), 0);
    chk("rst.bad", int'(bad), 0);
    rst_n = 1'b1;

    // frame_start while idle must not start anything
    rv_n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      frame_start = (k % 5 == 0);
      drive_pix(0);
      if (result_valid) rv_n++;
    end
    frame_start = 1'b0; de = 1'b0;
    @(negedge clk);
    chk("idle_fs.busy", int'(busy), 0);
    chk("idle_fs.rv", rv_n, 0);

    judge("perfect", 1000, 0, 0, 0, 0, 0, 0);
    judge("good", 600, 400, 20, 0, 0, 0, 0);
    judge("b79", 799, 201, 10, 0, 0, 0, 0);
    judge("b80", 800, 200, 10, 0, 0, 0, 0);
    judge("b49", 499, 501, 10, 0, 0, 0, 0);
    judge("b50", 500, 500, 10, 0, 0, 0, 0);
    judge("empty", 0, 0, 30, 0, 0, 0, 0);
    judge("edge", 10, 0, 5, 1, 1, 0, 0);
    judge("dup_req", 300, 100, 10, 0, 0, 1, 1);

    // reset during DIV aborts the judgement
    @(negedge clk); judge_req = 1'b1;
    @(negedge clk); judge_req = 1'b0;
    @(negedge clk); frame_start = 1'b1; drive_pix(0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); frame_start = 1'b0; drive_pix(0);
    end
    @(negedge clk); frame_start = 1'b1; drive_pix(3);
    @(negedge clk); frame_start = 1'b0; de = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", int'(busy), 0);
    chk("abort.rv", int'(result_valid), 0);
    chk("abort.score", int'(score), 0);
    chk("abort.perfect", int'(perfect), 0);
    chk("abort.good", int'(good), 0);
    chk("abort.bad", int'(bad), 0);
    @(negedge clk); rst_n = 1'b1;
    rv_n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (result_valid) rv_n++;
    end
    chk("abort.no_rv", rv_n, 0);
    judge("after_rst", 70, 30, 8, 1, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      nh = int'($urandom_range(300, 0));
      nm = int'($urandom_range(300, 0));
      judge($sformatf("rand%0d", r), nh, nm, int'($urandom_range(40, 1)),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, n_bad);
    $finish;
  end

endmodule
